// File: rtl/fp_add_ctrl.sv
// fp_add_ctrl: round-robin front end for the shared single-precision add/round datapath.
// One op in flight: grant, register operands and mode strobes, wait DP_LATENCY, return result.
module fp_add_ctrl #(
    parameter int unsigned DP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [2:0]  req0_rm,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [2:0]  req1_rm,

    input  logic [2:0]  frm,

    output logic [31:0] dp_in1,
    output logic [31:0] dp_in2,
    output logic        dp_rne,
    output logic        dp_rtz,
    output logic        dp_rdn,
    output logic        dp_rup,
    output logic        dp_rmm,
    input  logic [31:0] dp_result,
    input  logic        dp_overflow,
    input  logic        dp_underflow,
    input  logic        dp_inexact,

    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic [2:0]  resp_flags,
    output logic        resp_illegal,

    output logic [2:0]  fflags,
    input  logic        fflags_clr,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [3:0] LatCnt = 4'(DP_LATENCY);

    state_e      r_state;
    state_e      w_state_d;
    logic        r_last_grant;
    logic        r_id;
    logic [3:0]  r_cnt;
    logic [31:0] r_dp_in1;
    logic [31:0] r_dp_in2;
    logic [4:0]  r_mode;  // {rmm, rup, rdn, rtz, rne}
    logic [31:0] r_resp_data;
    logic [2:0]  r_resp_flags;
    logic        r_resp_illegal;
    logic [2:0]  r_fflags;

    logic        w_idle;
    logic        w_any;
    logic        w_gnt_id;
    logic        w_accept;
    logic        w_exec_done;
    logic        w_resp_hs;
    logic        w_rm_legal;
    logic [2:0]  w_sel_rm;
    logic [2:0]  w_eff_rm;
    logic [4:0]  w_mode;
    logic [31:0] w_sel_in1;
    logic [31:0] w_sel_in2;

    // Arbitration: a lone requester wins; on contention the one not served last wins.
    assign w_idle      = (r_state == StIdle);
    assign w_any       = req0_valid | req1_valid;
    assign w_gnt_id    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_accept    = w_idle & w_any;
    assign w_exec_done = (r_state == StExec) && (r_cnt == 4'd0);
    assign w_resp_hs   = (r_state == StResp) & resp_ready;

    assign req0_ready = w_accept & ~w_gnt_id;
    assign req1_ready = w_accept & w_gnt_id;

    assign w_sel_rm  = w_gnt_id ? req1_rm  : req0_rm;
    assign w_sel_in1 = w_gnt_id ? req1_in1 : req0_in1;
    assign w_sel_in2 = w_gnt_id ? req1_in2 : req0_in2;
    assign w_eff_rm  = (w_sel_rm == 3'b111) ? frm : w_sel_rm;

    always_comb begin
        w_mode     = 5'b00000;
        w_rm_legal = 1'b1;
        case (w_eff_rm)
            3'b000:  w_mode = 5'b00001;
            3'b001:  w_mode = 5'b00010;
            3'b010:  w_mode = 5'b00100;
            3'b011:  w_mode = 5'b01000;
            3'b100:  w_mode = 5'b10000;
            default: w_rm_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_d = w_rm_legal ? StExec : StResp;
                end
            end
            StExec: begin
                if (r_cnt == 4'd0) begin
                    w_state_d = StResp;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Issue registers stay frozen from accept until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_dp_in1     <= 32'd0;
            r_dp_in2     <= 32'd0;
            r_mode       <= 5'b00000;
            r_cnt        <= 4'd0;
        end else if (w_accept) begin
            r_last_grant <= w_gnt_id;
            r_id         <= w_gnt_id;
            r_dp_in1     <= w_sel_in1;
            r_dp_in2     <= w_sel_in2;
            r_mode       <= w_mode;
            if (w_rm_legal) begin
                r_cnt <= LatCnt;
            end
        end else if ((r_state == StExec) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_data    <= 32'd0;
            r_resp_flags   <= 3'b000;
            r_resp_illegal <= 1'b0;
        end else if (w_accept && !w_rm_legal) begin
            r_resp_data    <= 32'd0;
            r_resp_flags   <= 3'b000;
            r_resp_illegal <= 1'b1;
        end else if (w_exec_done) begin
            r_resp_data    <= dp_result;
            r_resp_flags   <= {dp_overflow, dp_underflow, dp_inexact};
            r_resp_illegal <= 1'b0;
        end
    end

    // Clear wins over a same-cycle accumulate; illegal responses never touch the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fflags <= 3'b000;
        end else if (fflags_clr) begin
            r_fflags <= 3'b000;
        end else if (w_resp_hs && !r_resp_illegal) begin
            r_fflags <= r_fflags | r_resp_flags;
        end
    end

    assign dp_in1 = r_dp_in1;
    assign dp_in2 = r_dp_in2;
    assign dp_rne = r_mode[0];
    assign dp_rtz = r_mode[1];
    assign dp_rdn = r_mode[2];
    assign dp_rup = r_mode[3];
    assign dp_rmm = r_mode[4];

    assign resp_valid   = (r_state == StResp);
    assign resp_id      = r_id;
    assign resp_data    = r_resp_data;
    assign resp_flags   = r_resp_flags;
    assign resp_illegal = r_resp_illegal;
    assign fflags       = r_fflags;
    assign busy         = (r_state != StIdle);

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Scoreboard bench for fp_add_ctrl: a latency-aware datapath stub, an accept observer that
// predicts responses, and a monitor that checks each response, its timing and sticky flags.
module tb_fp_add_ctrl;

    localparam int LAT = 1;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [2:0]  req0_rm, req1_rm, frm;
    logic [31:0] dp_in1, dp_in2, dp_result;
    logic        dp_rne, dp_rtz, dp_rdn, dp_rup, dp_rmm;
    logic        dp_overflow, dp_underflow, dp_inexact;
    logic        resp_valid, resp_ready, resp_id, resp_illegal;
    logic [31:0] resp_data;
    logic [2:0]  resp_flags, fflags;
    logic        fflags_clr, busy;

    fp_add_ctrl #(.DP_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1),
        .req0_in2(req0_in2), .req0_rm(req0_rm),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1),
        .req1_in2(req1_in2), .req1_rm(req1_rm),
        .frm(frm),
        .dp_in1(dp_in1), .dp_in2(dp_in2),
        .dp_rne(dp_rne), .dp_rtz(dp_rtz), .dp_rdn(dp_rdn), .dp_rup(dp_rup), .dp_rmm(dp_rmm),
        .dp_result(dp_result), .dp_overflow(dp_overflow), .dp_underflow(dp_underflow),
        .dp_inexact(dp_inexact),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_flags(resp_flags), .resp_illegal(resp_illegal),
        .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
    );

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [2:0]  flags;
        logic        illegal;
        logic [4:0]  mode;
        logic [31:0] in1;
        logic [31:0] in2;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          age = 0;
    int          acc_cnt = 0;
    bit          acc_flag = 0;
    bit          last_acc_id = 0;
    bit          m_last = 1'b1;
    logic [2:0]  m_ff = 3'b000;
    bit          prev_valid = 0;
    logic        hold_id, hold_ill;
    logic [31:0] hold_data;
    logic [2:0]  hold_flags;
    logic [4:0]  strobes;
    logic [34:0] stub_out;
    int          stub_mode;

    assign strobes = {dp_rmm, dp_rup, dp_rdn, dp_rtz, dp_rne};

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference datapath: known IEEE cases from the test plan, otherwise a mode-dependent hash.
    function automatic logic [34:0] ref_dp(input logic [31:0] a, input logic [31:0] b,
                                           input int mode);
        logic [31:0] r;
        if (a == 32'h3f80_0000 && b == 32'h4000_0000 && mode == 0)
            return {3'b000, 32'h4040_0000};
        if (a == 32'h7f7f_ffff && b == 32'h7f7f_ffff && mode == 0)
            return {3'b101, 32'h7f80_0000};
        if (a == 32'h7f7f_ffff && b == 32'h7f7f_ffff && mode == 1)
            return {3'b101, 32'h7f7f_ffff};
        r = a + {b[15:0], b[31:16]} + 32'(mode) * 32'h0101_0101;
        return {r[31:29] ^ a[2:0], r};
    endfunction

    // Stub presents garbage until operands have been stable LAT cycles or strobes are not one-hot.
    always_comb begin
        stub_mode = 7;
        for (int i = 0; i < 5; i++) begin
            if (strobes == 5'(1 << i)) stub_mode = i;
        end
        if (age >= LAT && stub_mode < 5) stub_out = ref_dp(dp_in1, dp_in2, stub_mode);
        else stub_out = {3'b111, 32'hdead_beef};
    end
    assign dp_result = stub_out[31:0];
    assign {dp_overflow, dp_underflow, dp_inexact} = stub_out[34:32];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        age <= acc_flag ? 0 : ((age < 1000) ? age + 1 : age);
    end

    // Observer: predict the grant and push the expected response for the coming accept edge.
    always @(negedge clk) begin : observer
        logic        g, any, ill;
        logic [2:0]  rm, eff;
        logic [31:0] a, b;
        logic [34:0] r;
        exp_t        e;
        if (!rst_n) begin
            m_last   = 1'b1;
            acc_flag = 1'b0;
        end else begin
            acc_flag = 1'b0;
            if (!busy) begin
                any = req0_valid | req1_valid;
                g   = (req0_valid & req1_valid) ? ~m_last : req1_valid;
                chk("req0_ready", req0_ready, any & ~g);
                chk("req1_ready", req1_ready, any & g);
                if (any) begin
                    rm  = g ? req1_rm : req0_rm;
                    a   = g ? req1_in1 : req0_in1;
                    b   = g ? req1_in2 : req0_in2;
                    eff = (rm == 3'b111) ? frm : rm;
                    ill = (eff > 3'd4);
                    r   = ref_dp(a, b, int'(eff));
                    e.id      = g;
                    e.illegal = ill;
                    e.data    = ill ? 32'd0 : r[31:0];
                    e.flags   = ill ? 3'b000 : r[34:32];
                    e.mode    = ill ? 5'b00000 : 5'(1 << eff);
                    e.in1     = a;
                    e.in2     = b;
                    e.due     = cyc + 1 + (ill ? 0 : LAT + 1);
                    sb.push_back(e);
                    m_last      = g;
                    acc_flag    = 1'b1;
                    last_acc_id = g;
                    acc_cnt++;
                end
            end
        end
    end

    // Monitor: check responses, hold stability, EXEC outputs and the sticky flag model.
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [2:0] nf;
        if (!rst_n) begin
            prev_valid = 0;
            m_ff       = 3'b000;
        end else begin
            chk("fflags", fflags, m_ff);
            nf = m_ff;
            if (resp_valid) begin
                chk("ready_in_resp", {req0_ready, req1_ready}, 2'b00);
                chk("busy_in_resp", busy, 1'b1);
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL unexpected_resp: got resp_valid expected none");
                    end else begin
                        e = sb[0];
                        chk("latency", cyc, e.due);
                        chk("resp_id", resp_id, e.id);
                        chk("resp_data", resp_data, e.data);
                        chk("resp_flags", resp_flags, e.flags);
                        chk("resp_illegal", resp_illegal, e.illegal);
                        chk("resp_strobes", strobes, e.mode);
                    end
                    hold_id    = resp_id;
                    hold_ill   = resp_illegal;
                    hold_data  = resp_data;
                    hold_flags = resp_flags;
                end else begin
                    chk("hold", {hold_id, hold_ill, hold_flags, hold_data},
                        {resp_id, resp_illegal, resp_flags, resp_data});
                end
                if (resp_ready && sb.size() > 0) begin
                    nf = m_ff | sb[0].flags;
                    void'(sb.pop_front());
                end
            end else if (busy && sb.size() > 0) begin
                chk("exec_strobes", strobes, sb[0].mode);
                chk("exec_ops", {dp_in1, dp_in2}, {sb[0].in1, sb[0].in2});
            end
            if (fflags_clr) nf = 3'b000;
            m_ff       = nf;
            prev_valid = resp_valid & ~resp_ready;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    task automatic issue(input bit r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] rm);
        int start;
        bit done;
        start = acc_cnt;
        done  = 0;
        if (r) begin
            req1_valid = 1'b1; req1_in1 = a; req1_in2 = b; req1_rm = rm;
        end else begin
            req0_valid = 1'b1; req0_in1 = a; req0_in2 = b; req0_rm = rm;
        end
        for (int i = 0; i < 50 && !done; i++) begin
            step();
            if (acc_cnt != start) done = 1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!done) fail_now("accept_timeout");
    endtask

    task automatic wait_done();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (!busy && sb.size() == 0) done = 1;
            else step();
        end
        if (!done) fail_now("done_timeout");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [2:0] ff_snap;
        bit [3:0]   order;
        int         seen, got;
        bit         flag;
        req0_valid = 0; req1_valid = 0; req0_in1 = 0; req0_in2 = 0; req0_rm = 0;
        req1_in1 = 0; req1_in2 = 0; req1_rm = 0; frm = 0; resp_ready = 1; fflags_clr = 0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp", {resp_valid, resp_id, resp_illegal, resp_flags, resp_data}, 64'd0);
        chk("rst_dp", {dp_in1, dp_in2}, 64'd0);
        chk("rst_strobes", strobes, 5'b00000);
        chk("rst_fflags", fflags, 3'b000);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Simple add, then overflow under RNE and RTZ, then clear.
        issue(0, 32'h3f80_0000, 32'h4000_0000, 3'b000);
        wait_done();
        chk("t1_fflags", fflags, 3'b000);
        issue(0, 32'h7f7f_ffff, 32'h7f7f_ffff, 3'b000);
        wait_done();
        chk("of_fflags", fflags, 3'b101);
        issue(0, 32'h7f7f_ffff, 32'h7f7f_ffff, 3'b001);
        wait_done();
        chk("of_rtz_fflags", fflags, 3'b101);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        chk("clr_fflags", fflags, 3'b000);

        // Dynamic mode, then an illegal mode.
        frm = 3'b010;
        issue(1, 32'h1234_5678, 32'h0bad_cafe, 3'b111);
        chk("dyn_rdn", strobes, 5'b00100);
        wait_done();
        ff_snap = m_ff;
        frm = 3'b000;
        issue(0, 32'h4120_0000, 32'h4130_0000, 3'b101);
        chk("ill_fast", {resp_valid, resp_illegal}, 2'b11);
        chk("ill_data", resp_data, 32'd0);
        chk("ill_strobes", strobes, 5'b00000);
        wait_done();
        chk("ill_fflags", fflags, ff_snap);

        // Backpressure: response held while requesters wait.
        resp_ready = 1'b0;
        issue(0, 32'h4040_0000, 32'h3f00_0000, 3'b011);
        flag = 0;
        for (int i = 0; i < 10 && !flag; i++) begin
            if (resp_valid) flag = 1;
            else step();
        end
        if (!flag) fail_now("resp_timeout");
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_stall", {resp_valid, busy, req0_ready, req1_ready}, 4'b1100);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        wait_done();

        // Reset while in EXEC discards the op and restores req0 priority.
        issue(1, 32'h5555_0000, 32'h0000_aaaa, 3'b001);
        chk("pre_rst_exec", {busy, resp_valid}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {busy, resp_valid, req0_ready, req1_ready}, 4'b0000);
        chk("mid_rst_resp", {resp_id, resp_illegal, resp_flags, resp_data}, 64'd0);
        chk("mid_rst_dp", {dp_in1, dp_in2}, 64'd0);
        chk("mid_rst_strobes", strobes, 5'b00000);
        chk("mid_rst_fflags", fflags, 3'b000);
        sb.delete();
        step();
        rst_n = 1'b1;
        step();

        // Contention: grants alternate 0,1,0,1 starting from req0.
        order = 4'b1010;
        req0_in1 = $urandom; req0_in2 = $urandom; req0_rm = 3'b000;
        req1_in1 = $urandom; req1_in2 = $urandom; req1_rm = 3'b001;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        seen = acc_cnt;
        got  = 0;
        for (int i = 0; i < 200 && got < 4; i++) begin
            step();
            if (acc_cnt != seen) begin
                seen = acc_cnt;
                chk($sformatf("grant_order%0d", got), last_acc_id, order[got]);
                got++;
                if (last_acc_id) req1_in1 = $urandom;
                else req0_in1 = $urandom;
                if (got == 4) begin
                    req0_valid = 1'b0;
                    req1_valid = 1'b0;
                end
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (got != 4) fail_now("contention_timeout");
        wait_done();

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_in1 = $urandom; req0_in2 = $urandom;
            req1_in1 = $urandom; req1_in2 = $urandom;
            req0_rm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7))
                                                  : 3'($urandom_range(0, 4));
            req1_rm = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7))
                                                  : 3'($urandom_range(0, 4));
            frm = 3'($urandom_range(0, 7));
            resp_ready = ($urandom_range(0, 3) != 0);
            fflags_clr = ($urandom_range(0, 19) == 0);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        fflags_clr = 1'b0;
        wait_done();
        step();
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
